// File: rtl/note_pkg.sv
// Shared constants and types for the note lane, also imported by the renderer.
package note_pkg;

  localparam int N_SLOTS = 10;
  localparam int CELL_W  = 7;
  localparam int SCORE_W = 16;
  localparam int COMBO_W = 8;
  localparam int OFS_W   = 3;

  localparam logic COL_RED  = 1'b0;
  localparam logic COL_BLUE = 1'b1;

  typedef logic [N_SLOTS-1:0] lane_t;
  typedef logic [OFS_W-1:0]   ofs_t;

  // Move every slot one place toward slot 0 and load the spawn slot with fill.
  function automatic lane_t lane_shift(input lane_t lane_in, input logic fill);
    return {fill, lane_in[N_SLOTS-1:1]};
  endfunction

endpackage

// File: rtl/note_scroller_score_keeper.sv
// Score and combo counters; a break (bad or miss) wins over a hit in the same cycle.
module score_keeper #(
  parameter int SCORE_W = 16,
  parameter int COMBO_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               hit,
  input  logic               bad,
  input  logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic [COMBO_W-1:0] combo
);

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [COMBO_W-1:0] COMBO_MAX = '1;

  logic [SCORE_W-1:0] score_next;
  logic [COMBO_W-1:0] combo_next;

  // Next-value selection with saturation and break priority.
  always_comb begin
    score_next = score;
    combo_next = combo;
    if (hit && (score != SCORE_MAX)) begin
      score_next = score + SCORE_W'(1);
    end
    if (bad || miss) begin
      combo_next = '0;
    end else if (hit && (combo != COMBO_MAX)) begin
      combo_next = combo + COMBO_W'(1);
    end
  end

  // Counter registers with synchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score <= '0;
      combo <= '0;
    end else if (clear) begin
      score <= '0;
      combo <= '0;
    end else begin
      score <= score_next;
      combo <= combo_next;
    end
  end

endmodule

// File: rtl/note_scroller.sv
// Note lane: scrolls notes toward the judge slot, spawns at the right edge,
// judges presses at slot 0 and drives the score keeper.
module note_scroller
  import note_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               clear,
  input  logic               tick,
  input  logic               spawn_valid,
  input  logic               spawn_blue,
  output logic               spawn_ready,
  input  logic               press_red,
  input  logic               press_blue,
  output logic [N_SLOTS-1:0] red_notes,
  output logic [N_SLOTS-1:0] blue_notes,
  output logic [OFS_W-1:0]   offset,
  output logic               hit,
  output logic               bad,
  output logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic [COMBO_W-1:0] combo
);

  localparam ofs_t OFS_LAST = ofs_t'(CELL_W - 1);

  logic  step;
  logic  wrap;
  logic  hit_red;
  logic  hit_blue;
  logic  hit_ev;
  logic  bad_ev;
  logic  miss_ev;
  logic  take_red;
  logic  take_blue;
  lane_t red_next;
  lane_t blue_next;
  ofs_t  offset_next;

  // Scroll timing and spawn handshake.
  always_comb begin
    step        = run & tick;
    wrap        = step & (offset == OFS_LAST);
    spawn_ready = rst_n & wrap & ~clear;
    take_red    = wrap & spawn_valid & (spawn_blue == COL_RED);
    take_blue   = wrap & spawn_valid & (spawn_blue == COL_BLUE);
    offset_next = offset;
    if (step) begin
      offset_next = (offset == OFS_LAST) ? '0 : offset + ofs_t'(1);
    end
  end

  // Judging against the pre-edge contents of slot 0.
  always_comb begin
    hit_red  = run & press_red  & red_notes[0];
    hit_blue = run & press_blue & blue_notes[0];
    hit_ev   = hit_red | hit_blue;
    bad_ev   = run & ((press_red & ~red_notes[0]) | (press_blue & ~blue_notes[0]));
    miss_ev  = wrap & (red_notes[0] | blue_notes[0]) & ~hit_ev;
  end

  // Lane update: a wrap shifts (old slot 1 replaces slot 0 even on a hit);
  // otherwise a hit just empties slot 0.
  always_comb begin
    red_next  = red_notes;
    blue_next = blue_notes;
    if (wrap) begin
      red_next  = lane_shift(red_notes, take_red);
      blue_next = lane_shift(blue_notes, take_blue);
    end else if (hit_ev) begin
      red_next[0]  = 1'b0;
      blue_next[0] = 1'b0;
    end
  end

  // Lane, offset and event-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_notes  <= '0;
      blue_notes <= '0;
      offset     <= '0;
      hit        <= 1'b0;
      bad        <= 1'b0;
      miss       <= 1'b0;
    end else if (clear) begin
      red_notes  <= '0;
      blue_notes <= '0;
      offset     <= '0;
      hit        <= 1'b0;
      bad        <= 1'b0;
      miss       <= 1'b0;
    end else begin
      red_notes  <= red_next;
      blue_notes <= blue_next;
      offset     <= offset_next;
      hit        <= hit_ev;
      bad        <= bad_ev;
      miss       <= miss_ev;
    end
  end

  score_keeper #(
    .SCORE_W (SCORE_W),
    .COMBO_W (COMBO_W)
  ) u_score_keeper (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .hit   (hit_ev),
    .bad   (bad_ev),
    .miss  (miss_ev),
    .score (score),
    .combo (combo)
  );

endmodule

// File: tb/tb_note_scroller.sv
// Directed bench for note_scroller.
module tb_note_scroller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        clear;
  logic        tick;
  logic        spawn_valid;
  logic        spawn_blue;
  logic        spawn_ready;
  logic        press_red;
  logic        press_blue;
  logic [9:0]  red_notes;
  logic [9:0]  blue_notes;
  logic [2:0]  offset;
  logic        hit;
  logic        bad;
  logic        miss;
  logic [15:0] score;
  logic [7:0]  combo;

  int tests = 0;
  int fails = 0;

  note_scroller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .clear       (clear),
    .tick        (tick),
    .spawn_valid (spawn_valid),
    .spawn_blue  (spawn_blue),
    .spawn_ready (spawn_ready),
    .press_red   (press_red),
    .press_blue  (press_blue),
    .red_notes   (red_notes),
    .blue_notes  (blue_notes),
    .offset      (offset),
    .hit         (hit),
    .bad         (bad),
    .miss        (miss),
    .score       (score),
    .combo       (combo)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_once();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  // Advance to offset 6, wrap once (optionally spawning), then 9 more wraps.
  task automatic load_slot0(input logic blue);
    int guard;
    guard = 0;
    while (offset != 3'd6 && guard < 20) begin
      tick_once();
      guard++;
    end
    tests++;
    if (guard >= 20) begin
      fails++;
      $display("FAIL load_align: offset %0d never reached 6", offset);
    end
    spawn_valid = 1'b1;
    spawn_blue  = blue;
    tick_once();
    spawn_valid = 1'b0;
    spawn_blue  = 1'b0;
    repeat (63) tick_once();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; clear = 1'b0; tick = 1'b0;
    spawn_valid = 1'b0; spawn_blue = 1'b0; press_red = 1'b0; press_blue = 1'b0;
    cyc(); cyc();
    tests++;
    if ({red_notes, blue_notes, offset, hit, bad, miss, score, combo, spawn_ready} !== '0) begin
      fails++;
      $display("FAIL reset_state: red=%b blue=%b ofs=%0d score=%0d combo=%0d rdy=%b, want all 0",
               red_notes, blue_notes, offset, score, combo, spawn_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_scroll_spawn();
    run = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick = 1'b1;
      #1;
      tests++;
      if (spawn_ready !== 1'b0) begin
        fails++;
        $display("FAIL ready_early: got %b want 0 at step %0d", spawn_ready, i);
      end
      cyc();
      tick = 1'b0;
      tests++;
      if (offset !== 3'(i) || red_notes !== 10'd0 || blue_notes !== 10'd0) begin
        fails++;
        $display("FAIL scroll_step%0d: ofs=%0d red=%b blue=%b want ofs=%0d lanes 0",
                 i, offset, red_notes, blue_notes, i);
      end
    end
    spawn_valid = 1'b1; spawn_blue = 1'b1; tick = 1'b1;
    #1;
    tests++;
    if (spawn_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_wrap: got %b want 1", spawn_ready);
    end
    cyc();
    tick = 1'b0; spawn_valid = 1'b0; spawn_blue = 1'b0;
    tests++;
    if (offset !== 3'd0 || blue_notes !== 10'b1000000000 || red_notes !== 10'd0) begin
      fails++;
      $display("FAIL spawn_blue: ofs=%0d blue=%b red=%b want 0/1000000000/0", offset, blue_notes, red_notes);
    end
    repeat (63) tick_once();
    tests++;
    if (blue_notes !== 10'b0000000001 || red_notes !== 10'd0) begin
      fails++;
      $display("FAIL scroll_to_slot0: blue=%b red=%b want 0000000001/0", blue_notes, red_notes);
    end
    clear = 1'b1; cyc(); clear = 1'b0;
    tests++;
    if (blue_notes !== 10'd0 || offset !== 3'd0) begin
      fails++;
      $display("FAIL clear_lane: blue=%b ofs=%0d want 0/0", blue_notes, offset);
    end
  endtask

  task automatic test_hit_bad();
    load_slot0(1'b0);
    tests++;
    if (red_notes !== 10'b0000000001) begin
      fails++;
      $display("FAIL load_red: red=%b want 0000000001", red_notes);
    end
    press_red = 1'b1; cyc(); press_red = 1'b0;
    tests++;
    if (hit !== 1'b1 || bad !== 1'b0 || red_notes !== 10'd0 || score !== 16'd1 || combo !== 8'd1) begin
      fails++;
      $display("FAIL hit_red: hit=%b bad=%b red=%b score=%0d combo=%0d want 1/0/0/1/1",
               hit, bad, red_notes, score, combo);
    end
    cyc();
    tests++;
    if (hit !== 1'b0) begin
      fails++;
      $display("FAIL hit_pulse: hit=%b want 0", hit);
    end
    press_red = 1'b1; cyc(); press_red = 1'b0;
    tests++;
    if (bad !== 1'b1 || hit !== 1'b0 || combo !== 8'd0 || score !== 16'd1) begin
      fails++;
      $display("FAIL bad_press: bad=%b hit=%b combo=%0d score=%0d want 1/0/0/1", bad, hit, combo, score);
    end
  endtask

  task automatic test_miss();
    load_slot0(1'b0);
    press_red = 1'b1; cyc(); press_red = 1'b0;
    tests++;
    if (score !== 16'd2 || combo !== 8'd1) begin
      fails++;
      $display("FAIL miss_setup: score=%0d combo=%0d want 2/1", score, combo);
    end
    load_slot0(1'b0);
    repeat (6) tick_once();
    tick_once();
    tests++;
    if (miss !== 1'b1 || combo !== 8'd0 || score !== 16'd2 || red_notes !== 10'd0) begin
      fails++;
      $display("FAIL miss_wrap: miss=%b combo=%0d score=%0d red=%b want 1/0/2/0", miss, combo, score, red_notes);
    end
    load_slot0(1'b0);
    repeat (6) tick_once();
    press_red = 1'b1; tick_once(); press_red = 1'b0;
    tests++;
    if (hit !== 1'b1 || miss !== 1'b0 || score !== 16'd3 || combo !== 8'd1 || red_notes !== 10'd0) begin
      fails++;
      $display("FAIL hit_on_wrap: hit=%b miss=%b score=%0d combo=%0d red=%b want 1/0/3/1/0",
               hit, miss, score, combo, red_notes);
    end
  endtask

  task automatic test_dual_press();
    load_slot0(1'b1);
    press_red = 1'b1; press_blue = 1'b1; cyc();
    press_red = 1'b0; press_blue = 1'b0;
    tests++;
    if (hit !== 1'b1 || bad !== 1'b1 || score !== 16'd4 || combo !== 8'd0 || blue_notes !== 10'd0) begin
      fails++;
      $display("FAIL dual_press: hit=%b bad=%b score=%0d combo=%0d blue=%b want 1/1/4/0/0",
               hit, bad, score, combo, blue_notes);
    end
  endtask

  task automatic test_frozen();
    run = 1'b0; tick = 1'b1; press_red = 1'b1;
    #1;
    tests++;
    if (spawn_ready !== 1'b0) begin
      fails++;
      $display("FAIL frozen_ready: got %b want 0", spawn_ready);
    end
    cyc();
    tick = 1'b0; press_red = 1'b0;
    tests++;
    if (offset !== 3'd0 || bad !== 1'b0 || hit !== 1'b0 || score !== 16'd4) begin
      fails++;
      $display("FAIL frozen: ofs=%0d bad=%b hit=%b score=%0d want 0/0/0/4", offset, bad, hit, score);
    end
    run = 1'b1;
  endtask

  task automatic test_saturation();
    clear = 1'b1; cyc(); clear = 1'b0;
    tests++;
    if (score !== 16'd0 || combo !== 8'd0) begin
      fails++;
      $display("FAIL clear_counters: score=%0d combo=%0d want 0/0", score, combo);
    end
    spawn_valid = 1'b1; spawn_blue = 1'b0;
    repeat (70) tick_once();
    tests++;
    if (red_notes !== 10'h3FF || miss !== 1'b0) begin
      fails++;
      $display("FAIL fill_lane: red=%b miss=%b want 1111111111/0", red_notes, miss);
    end
    for (int h = 1; h <= 256; h++) begin
      repeat (6) tick_once();
      press_red = 1'b1; tick_once(); press_red = 1'b0;
      if (h == 255) begin
        tests++;
        if (combo !== 8'd255) begin
          fails++;
          $display("FAIL combo_255: combo=%0d want 255", combo);
        end
      end
    end
    spawn_valid = 1'b0;
    tests++;
    if (combo !== 8'd255 || score !== 16'd256 || hit !== 1'b1) begin
      fails++;
      $display("FAIL combo_sat: combo=%0d score=%0d hit=%b want 255/256/1", combo, score, hit);
    end
  endtask

  task automatic test_async_reset();
    repeat (3) tick_once();
    @(negedge clk);
    tick = 1'b1; spawn_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({red_notes, blue_notes, offset, hit, bad, miss, score, combo, spawn_ready} !== '0) begin
      fails++;
      $display("FAIL async_reset: red=%b ofs=%0d score=%0d combo=%0d rdy=%b want all 0",
               red_notes, offset, score, combo, spawn_ready);
    end
    tick = 1'b0; spawn_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    test_reset();
    test_scroll_spawn();
    test_hit_bad();
    test_miss();
    test_dual_press();
    test_frozen();
    test_saturation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/note_scroller.md
Name: note_scroller

Overview:
- Upstream stage of the note-drawing stage. Owns the 10-slot note lane: per-slot red/blue occupancy plus a sub-cell pixel offset, consumed by the renderer as red_notes, blue_notes and offset.
- Scrolls notes leftwards one pixel per tick and accepts new notes from the chart sequencer at the right edge via a valid/ready handshake.
- Judges player presses at slot 0 and keeps score and combo.

Parameters:
- N_SLOTS, 10, number of note slots (slot 0 = leftmost/judge slot, slot N_SLOTS-1 = spawn slot)
- CELL_W, 7, pixel width of one note cell; offset counts 0..CELL_W-1
- SCORE_W, 16, score counter width
- COMBO_W, 8, combo counter width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  1 = lane advances and presses are judged; 0 = frozen
- clear  in  1  synchronous clear of lane, offset, score and combo
- tick  in  1  one-cycle scroll-step pulse (frame-rate divider)
- spawn_valid  in  1  chart sequencer offers a note
- spawn_blue  in  1  colour of offered note (0 red, 1 blue)
- spawn_ready  out  1  note accepted this cycle when spawn_valid is also 1
- press_red  in  1  one-cycle debounced red button pulse
- press_blue  in  1  one-cycle debounced blue button pulse
- red_notes  out  N_SLOTS  red occupancy per slot
- blue_notes  out  N_SLOTS  blue occupancy per slot
- offset  out  3  pixel offset 0..CELL_W-1
- hit  out  1  pulse: correct press
- bad  out  1  pulse: press with no matching note at slot 0
- miss  out  1  pulse: note left slot 0 unhit
- score  out  SCORE_W  hits, saturating
- combo  out  COMBO_W  consecutive hits, saturating

Behaviour:
- Reset (rst_n low, async): red_notes=0, blue_notes=0, offset=0, hit=bad=miss=0, score=0, combo=0. spawn_ready is combinational and is 0 while rst_n is low.
- clear=1 (synchronous): same values as reset on the next edge. clear has priority over everything else.
- Invariant: red_notes & blue_notes == 0 at all times.
- Step event: step = run & tick.
  - If offset < CELL_W-1: offset += 1 at the next edge.
  - If offset == CELL_W-1 (wrap): offset <= 0, and both lanes shift toward slot 0 (slot i <= slot i+1).
- Spawn handshake:
  - spawn_ready = rst_n & run & tick & (offset == CELL_W-1) & ~clear.
  - On a wrap, slot N_SLOTS-1 loads the offered note if spawn_valid=1 (red if spawn_blue=0, blue if 1). Otherwise it loads empty.
  - The sequencer holds spawn_valid and spawn_blue until accepted.
- Judging (run=1 only; presses are ignored when run=0). Always uses pre-edge slot 0 contents.
  - press_red with red_notes[0]=1, or press_blue with blue_notes[0]=1: hit pulse; slot 0 is cleared.
  - Any other press: bad pulse; lane unchanged.
  - Both presses in one cycle: the matching one (if any) yields hit, the non-matching one yields bad. Both pulses may assert together.
- Miss: on a wrap, if pre-edge slot 0 is occupied and not hit this same cycle, miss pulses.
  - Hit and wrap in the same cycle: the note counts as hit, no miss; slot 0 takes old slot 1.
- Counters:
  - hit: score += 1, combo += 1, both saturating.
  - bad or miss: combo <= 0 (this takes priority over the increment in the same cycle); score is unchanged.
- Latency: every output except spawn_ready is registered and reflects events one cycle after the causing inputs. hit, bad and miss are single-cycle pulses.

Decomposition:
- Shared package note_pkg: N_SLOTS, CELL_W, colour encoding (COL_RED=0, COL_BLUE=1). The renderer imports the same constants.
- One sub-module: score_keeper (inputs hit, bad, miss, clear; outputs score, combo; saturation and combo-reset priority).

Test Plan:
- Reset, then 6 ticks with run=1 -> offset steps 1..6 and lanes stay 0. 7th tick -> offset=0, spawn_ready high in that cycle.
- spawn_valid=1, spawn_blue=1 held over one wrap -> blue_notes=10'b1000000000, red_notes=0. After 9 more wraps with no spawns -> blue_notes[0]=1.
- Red note at slot 0, press_red -> next cycle hit=1, red_notes[0]=0, score=1, combo=1. Press_red again -> bad=1, combo=0, score=1.
- Red note at slot 0, no press, wrap -> miss=1, combo=0. Same setup but press_red on the wrap cycle -> hit=1, miss=0.
- Blue at slot 0, press_red and press_blue together -> hit=1 and bad=1 in the same cycle; combo ends at 0, score increments by 1.
- Combo at 255 plus a hit -> combo stays 255. Assert rst_n low mid-scroll -> all outputs 0 immediately, without waiting for a clock edge.
